mem_bus_scheduler: RTL and testbench
====================================

Name: mem_bus_scheduler

Overview:
- Shares the single split-transaction memory bus between the instruction-fetch client (i_) and the data-memory client (d_).
- Sits between the fetcher/datamemory stages and the top-level bus ports.
- Sequences one transaction at a time: address phase, write-data beats or read-response beats, then release.
- Gives each client its own request acknowledge and routes response beats by owner.

Parameters:
- DATA_W, 64, bus data/address width.
- TAG_W, 13, tag width; tag MSB = 1 marks a write.
- BEATS, 8, data beats per transaction (line size / DATA_W).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- i_reqcyc  in  1  fetch request valid; held until i_reqack.
- i_req  in  DATA_W  fetch address.
- i_reqtag  in  TAG_W  fetch tag.
- i_reqack  out  1  fetch address/beat accepted.
- i_respcyc  out  1  fetch response beat valid.
- i_resp  out  DATA_W  fetch response data.
- i_resptag  out  TAG_W  fetch response tag.
- i_respack  in  1  fetch consumes beat.
- d_reqcyc, d_req, d_reqtag, d_reqack, d_respcyc, d_resp, d_resptag, d_respack: same as the i_ group, for the data client.
- bus_reqcyc  out  1  bus request valid.
- bus_req  out  DATA_W  bus address / write data.
- bus_reqtag  out  TAG_W  bus tag.
- bus_reqack  in  1  bus accepted the current address/beat.
- bus_respcyc  in  1  bus response beat valid.
- bus_resp  in  DATA_W  response data.
- bus_resptag  in  TAG_W  response tag.
- bus_respack  out  1  response beat consumed.
- owner  out  2  00 none, 01 fetch, 10 data.
- stray_err  out  1  sticky: a response arrived while no read was outstanding.

Behaviour:
- States:
  - IDLE: no owner.
  - ADDR: owner's address driven.
  - WDATA: write beats forwarded.
  - RESP: read beats routed.
- Reset (synchronous):
  - state=IDLE, owner=00, rr_last=data (so fetch wins the first tie), beat_cnt=0, stray_err=0.
  - All reqack/respcyc/bus_reqcyc/bus_respack outputs 0.
  - Reset mid-transaction abandons it immediately; no further beats are acked.
- IDLE arbitration:
  - If exactly one reqcyc is high, that client is granted.
  - If both are high, the client not equal to rr_last is granted.
  - The grant registers owner and rr_last; next state is ADDR.
  - Latency: first bus_reqcyc appears the cycle after the client raises reqcyc.
- ADDR:
  - bus_reqcyc=1; bus_req/bus_reqtag pass through combinationally from the owner.
  - owner reqack = bus_reqack.
  - On bus_reqack: a tag MSB of 1 goes to WDATA, otherwise to RESP. beat_cnt=0.
- WDATA:
  - Same pass-through. Each bus_reqack increments beat_cnt and pulses the owner's reqack.
  - The owner holds reqcyc and presents the next beat after each ack.
  - When the ack arrives with beat_cnt==BEATS-1: go to IDLE, owner=00.
  - If the owner drops reqcyc in WDATA, bus_reqcyc follows it low; the state is held.
- RESP:
  - owner respcyc/resp/resptag = bus_respcyc/bus_resp/bus_resptag; bus_respack = owner respack.
  - The non-owner's respcyc is 0.
  - Each beat with respcyc & respack increments beat_cnt; the last beat (BEATS-1) goes to IDLE.
  - The response tag is not checked; routing is by owner only.
- Stray response: bus_respcyc in IDLE/ADDR/WDATA gives bus_respack=1 (beat dropped) and sets stray_err. stray_err clears only on reset.
- Non-owner reqack is always 0; a request that arrives during a transaction waits.
- beat_cnt width is clog2(BEATS) (minimum 1). It never wraps: its terminal value forces the state exit.
- A new grant can occur in the cycle after return to IDLE; there are no back-to-back grants without an IDLE cycle.

Optional Feature:
- SCHED_DATA_PRIO_EN defined: IDLE arbitration is fixed-priority, data over fetch. rr_last is unused.
- Undefined: round-robin as above.
- All other behaviour is identical.

Test Plan:
- Fetch read alone: i_reqcyc=1, i_req=0x1000, tag=0x0005, bus_reqack on cycle 2, then 8 beats 0xA0..0xA7. Required: bus_req=0x1000 in ADDR; i_respcyc carries A0..A7; owner returns to 00 after beat 8; d_respcyc stays 0.
- Data write: d_reqtag=0x1003 (MSB set), address 0x2000, then data 0xD0..0xD7, bus_reqack every cycle. Required: 9 d_reqack pulses; bus_req sequence 0x2000,0xD0..0xD7; no RESP state.
- Simultaneous requests from reset: both reqcyc high. Required: fetch is granted first, data next. After both re-request, the order alternates (fetch, data, fetch, data). With SCHED_DATA_PRIO_EN: data always first.
- Backpressure: in RESP, i_respack low for 3 cycles on beat 4. Required: bus_respack=0 for those cycles; beat_cnt holds; 8 beats total delivered.
- Stray beat: bus_respcyc=1 while IDLE. Required: bus_respack=1 that cycle; stray_err=1 and sticky until reset.
- Reset on beat 3 of a read: required next cycle: state IDLE, owner=00, all ack/cyc outputs 0, stray_err=0.

Source files
------------

// File: rtl/mem_bus_scheduler.sv
// mem_bus_scheduler: shares one split-transaction bus between fetch (i_) and data (d_) clients.
// Define SCHED_DATA_PRIO_EN for fixed data-over-fetch priority instead of round-robin.
module mem_bus_scheduler #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 13,
    parameter int BEATS  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_reqcyc,
    input  logic [DATA_W-1:0] i_req,
    input  logic [TAG_W-1:0]  i_reqtag,
    output logic              i_reqack,
    output logic              i_respcyc,
    output logic [DATA_W-1:0] i_resp,
    output logic [TAG_W-1:0]  i_resptag,
    input  logic              i_respack,
    input  logic              d_reqcyc,
    input  logic [DATA_W-1:0] d_req,
    input  logic [TAG_W-1:0]  d_reqtag,
    output logic              d_reqack,
    output logic              d_respcyc,
    output logic [DATA_W-1:0] d_resp,
    output logic [TAG_W-1:0]  d_resptag,
    input  logic              d_respack,
    output logic              bus_reqcyc,
    output logic [DATA_W-1:0] bus_req,
    output logic [TAG_W-1:0]  bus_reqtag,
    input  logic              bus_reqack,
    input  logic              bus_respcyc,
    input  logic [DATA_W-1:0] bus_resp,
    input  logic [TAG_W-1:0]  bus_resptag,
    output logic              bus_respack,
    output logic [1:0]        owner,
    output logic              stray_err
);
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ADDR  = 2'd1;
    localparam logic [1:0] WDATA = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;
    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_I    = 2'b01;
    localparam logic [1:0] OWN_D    = 2'b10;

    logic [1:0]       state;
    logic [CW-1:0]    beat_cnt;
    logic             own_i, own_d, own_reqcyc, own_respack;
    logic [TAG_W-1:0] own_tag;
    logic             req_phase, in_resp, req_fire, resp_fire, stray, last_beat;
    logic             gnt_i, gnt_d;

    assign own_i       = owner == OWN_I;
    assign own_d       = owner == OWN_D;
    assign own_reqcyc  = own_i ? i_reqcyc : (own_d & d_reqcyc);
    assign own_respack = own_i ? i_respack : (own_d & d_respack);
    assign own_tag     = own_i ? i_reqtag : d_reqtag;
    assign last_beat   = beat_cnt == LAST;

    // Outputs are gated by reset so an abandoned transaction gets no further acks.
    assign req_phase  = ~reset & (state == ADDR | state == WDATA);
    assign in_resp    = ~reset & (state == RESP);
    assign bus_reqcyc = ~reset & (state == ADDR | (state == WDATA & own_reqcyc));
    assign bus_req    = req_phase ? (own_i ? i_req : d_req) : '0;
    assign bus_reqtag = req_phase ? own_tag : '0;
    assign req_fire   = bus_reqcyc & bus_reqack;
    assign i_reqack   = own_i & req_fire;
    assign d_reqack   = own_d & req_fire;

    assign i_respcyc = in_resp & own_i & bus_respcyc;
    assign i_resp    = (in_resp & own_i) ? bus_resp : '0;
    assign i_resptag = (in_resp & own_i) ? bus_resptag : '0;
    assign d_respcyc = in_resp & own_d & bus_respcyc;
    assign d_resp    = (in_resp & own_d) ? bus_resp : '0;
    assign d_resptag = (in_resp & own_d) ? bus_resptag : '0;

    // A beat with no read outstanding is swallowed so the bus cannot stall on it.
    assign stray       = ~reset & bus_respcyc & (state != RESP);
    assign resp_fire   = in_resp & bus_respcyc & own_respack;
    assign bus_respack = stray | (in_resp & own_respack);

`ifdef SCHED_DATA_PRIO_EN
    assign gnt_d = d_reqcyc;
    assign gnt_i = i_reqcyc & ~d_reqcyc;
`else
    logic rr_last;
    assign gnt_i = i_reqcyc & (~d_reqcyc | rr_last);
    assign gnt_d = d_reqcyc & ~gnt_i;

    always_ff @(posedge clk) begin
        if (reset)
            rr_last <= 1'b1;
        else if (state == IDLE && (gnt_i || gnt_d))
            rr_last <= gnt_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= OWN_NONE;
            beat_cnt  <= '0;
            stray_err <= 1'b0;
        end else begin
            if (stray)
                stray_err <= 1'b1;
            case (state)
                IDLE: if (gnt_i || gnt_d) begin
                    state <= ADDR;
                    owner <= gnt_i ? OWN_I : OWN_D;
                end
                ADDR: if (req_fire) begin
                    state    <= own_tag[TAG_W-1] ? WDATA : RESP;
                    beat_cnt <= '0;
                end
                WDATA: if (req_fire) begin
                    if (last_beat) begin
                        state    <= IDLE;
                        owner    <= OWN_NONE;
                        beat_cnt <= '0;
                    end else
                        beat_cnt <= beat_cnt + 1'b1;
                end
                RESP: if (resp_fire) begin
                    if (last_beat) begin
                        state    <= IDLE;
                        owner    <= OWN_NONE;
                        beat_cnt <= '0;
                    end else
                        beat_cnt <= beat_cnt + 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_scheduler.sv
// tb_mem_bus_scheduler: table-driven and randomized transaction checks for mem_bus_scheduler.
`timescale 1ns/1ps
module tb_mem_bus_scheduler;
    localparam int DW = 64;
    localparam int TW = 13;
    localparam int NB = 8;
`ifdef SCHED_DATA_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          i_reqcyc, i_reqack, i_respcyc, i_respack;
    logic [DW-1:0] i_req, i_resp;
    logic [TW-1:0] i_reqtag, i_resptag;
    logic          d_reqcyc, d_reqack, d_respcyc, d_respack;
    logic [DW-1:0] d_req, d_resp;
    logic [TW-1:0] d_reqtag, d_resptag;
    logic          bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
    logic [DW-1:0] bus_req, bus_resp;
    logic [TW-1:0] bus_reqtag, bus_resptag;
    logic [1:0]    owner;
    logic          stray_err;

    mem_bus_scheduler #(.DATA_W(DW), .TAG_W(TW), .BEATS(NB)) dut (
        .clk(clk), .reset(reset),
        .i_reqcyc(i_reqcyc), .i_req(i_req), .i_reqtag(i_reqtag), .i_reqack(i_reqack),
        .i_respcyc(i_respcyc), .i_resp(i_resp), .i_resptag(i_resptag), .i_respack(i_respack),
        .d_reqcyc(d_reqcyc), .d_req(d_req), .d_reqtag(d_reqtag), .d_reqack(d_reqack),
        .d_respcyc(d_respcyc), .d_resp(d_resp), .d_resptag(d_resptag), .d_respack(d_respack),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
        .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
        .bus_respack(bus_respack), .owner(owner), .stray_err(stray_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            ri, rd;
        logic [TW-1:0] it, dt;
        logic [DW-1:0] ia, da, ib, db;
        int            gap, stall;
        bit            first_rr, first_pr;
    } vec_t;

    vec_t tbl[7];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   last_d = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit is_d, input bit cyc, input logic [DW-1:0] v, input logic [TW-1:0] tag);
        if (is_d) begin
            d_reqcyc = cyc; d_req = v; d_reqtag = tag;
        end else begin
            i_reqcyc = cyc; i_req = v; i_reqtag = tag;
        end
    endtask

    // Entered one cycle after the grant; leaves at the negedge of the IDLE cycle that follows.
    task automatic serve(input bit is_d, input logic [DW-1:0] addr, input logic [TW-1:0] tag,
                         input logic [DW-1:0] base, input int gap, input int stall_beat);
        logic [1:0] eo;
        eo = is_d ? 2'b10 : 2'b01;
        for (int g = 0; g <= gap; g++) begin
            bus_reqack = (g == gap);
            @(negedge clk);
            chk("addr_owner", 64'(owner), 64'(eo));
            chk("addr_cyc", 64'(bus_reqcyc), 64'd1);
            chk("addr_req", bus_req, addr);
            chk("addr_tag", 64'(bus_reqtag), 64'(tag));
            chk("addr_ack", 64'(is_d ? d_reqack : i_reqack), 64'(g == gap));
            chk("addr_other_ack", 64'(is_d ? i_reqack : d_reqack), 64'd0);
            tick;
        end
        if (tag[TW-1]) begin
            for (int k = 0; k < NB; k++) begin
                set_req(is_d, 1'b1, base + 64'(k), tag);
                bus_reqack = 1'b1;
                @(negedge clk);
                chk("wr_cyc", 64'(bus_reqcyc), 64'd1);
                chk("wr_data", bus_req, base + 64'(k));
                chk("wr_ack", 64'(is_d ? d_reqack : i_reqack), 64'd1);
                chk("wr_other_ack", 64'(is_d ? i_reqack : d_reqack), 64'd0);
                chk("wr_respcyc", 64'(i_respcyc | d_respcyc), 64'd0);
                tick;
            end
            set_req(is_d, 1'b0, '0, '0);
            bus_reqack = 1'b0;
        end else begin
            set_req(is_d, 1'b0, '0, '0);
            bus_reqack = 1'b0;
            for (int k = 0; k < NB; k++) begin
                int lim;
                lim = (k == stall_beat) ? 3 : 0;
                bus_respcyc = 1'b1;
                bus_resp    = base + 64'(k);
                bus_resptag = tag;
                for (int s = 0; s <= lim; s++) begin
                    bit ack;
                    ack = (s == lim);
                    if (is_d) d_respack = ack; else i_respack = ack;
                    @(negedge clk);
                    chk("rd_cyc", 64'(is_d ? d_respcyc : i_respcyc), 64'd1);
                    chk("rd_data", is_d ? d_resp : i_resp, base + 64'(k));
                    chk("rd_tag", 64'(is_d ? d_resptag : i_resptag), 64'(tag));
                    chk("rd_other_cyc", 64'(is_d ? i_respcyc : d_respcyc), 64'd0);
                    chk("rd_busack", 64'(bus_respack), 64'(ack));
                    chk("rd_owner", 64'(owner), 64'(eo));
                    tick;
                end
            end
            bus_respcyc = 1'b0;
            i_respack = 1'b1;
            d_respack = 1'b1;
        end
        @(negedge clk);
        chk("end_owner", 64'(owner), 64'd0);
        chk("end_cyc", 64'(bus_reqcyc), 64'd0);
    endtask

    task automatic round(input bit ri, input bit rd, input logic [TW-1:0] it, input logic [TW-1:0] dt,
                         input logic [DW-1:0] ia, input logic [DW-1:0] da,
                         input logic [DW-1:0] ib, input logic [DW-1:0] db,
                         input int gap, input int stall, input bit first_d);
        tick;
        if (ri) set_req(1'b0, 1'b1, ia, it);
        if (rd) set_req(1'b1, 1'b1, da, dt);
        @(negedge clk);
        chk("idle_owner", 64'(owner), 64'd0);
        chk("idle_cyc", 64'(bus_reqcyc), 64'd0);
        chk("idle_ack", 64'(i_reqack | d_reqack), 64'd0);
        tick;
        if (first_d) serve(1'b1, da, dt, db, gap, stall);
        else         serve(1'b0, ia, it, ib, gap, stall);
        if (ri && rd) begin
            tick;
            if (first_d) serve(1'b0, ia, it, ib, 0, -1);
            else         serve(1'b1, da, dt, db, 0, -1);
        end
    endtask

    initial begin
        tbl[0] = '{1, 1, 13'h0005, 13'h1003, 64'h1000, 64'h2000, 64'hA0, 64'hD0, 0, -1, 0, 1};
        tbl[1] = '{1, 1, 13'h0011, 13'h0022, 64'h1100, 64'h2100, 64'hB0, 64'hC0, 2, -1, 0, 1};
        tbl[2] = '{1, 0, 13'h0005, 13'h0000, 64'h1000, 64'h0,    64'hA0, 64'h0,  1, -1, 0, 0};
        tbl[3] = '{1, 1, 13'h1001, 13'h0007, 64'h1200, 64'h2200, 64'hE0, 64'hF0, 0, -1, 1, 1};
        tbl[4] = '{0, 1, 13'h0000, 13'h1003, 64'h0,    64'h2000, 64'h0,  64'hD0, 0, -1, 1, 1};
        tbl[5] = '{1, 0, 13'h0005, 13'h0000, 64'h1000, 64'h0,    64'hA0, 64'h0,  0,  4, 0, 0};
        tbl[6] = '{1, 1, 13'h0031, 13'h0032, 64'h1300, 64'h2300, 64'h50, 64'h60, 0, -1, 1, 1};

        reset = 1'b1;
        i_reqcyc = 0; i_req = '0; i_reqtag = '0; i_respack = 1'b1;
        d_reqcyc = 0; d_req = '0; d_reqtag = '0; d_respack = 1'b1;
        bus_reqack = 0; bus_respcyc = 0; bus_resp = '0; bus_resptag = '0;
        repeat (2) tick;
        @(negedge clk);
        chk("rst_owner", 64'(owner), 64'd0);
        chk("rst_buscyc", 64'(bus_reqcyc), 64'd0);
        chk("rst_respack", 64'(bus_respack), 64'd0);
        chk("rst_stray", 64'(stray_err), 64'd0);
        chk("rst_acks", 64'(i_reqack | d_reqack | i_respcyc | d_respcyc), 64'd0);
        tick;
        reset = 1'b0;

        foreach (tbl[n]) begin
            bit f;
            f = PRIO ? tbl[n].first_pr : tbl[n].first_rr;
            round(tbl[n].ri, tbl[n].rd, tbl[n].it, tbl[n].dt, tbl[n].ia, tbl[n].da,
                  tbl[n].ib, tbl[n].db, tbl[n].gap, tbl[n].stall, f);
            last_d = (tbl[n].ri && tbl[n].rd) ? ~f : f;
        end

        // Reference arbitration: a lone requester wins; a tie goes to data under
        // fixed priority, otherwise to whichever client was not served last.
        for (int r = 0; r < 40; r++) begin
            bit ri, rd, f;
            logic [TW-1:0] it, dt;
            ri = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            if (!ri && !rd) ri = 1'b1;
            it = {1'($urandom_range(0, 1)), 12'($urandom)};
            dt = {1'($urandom_range(0, 1)), 12'($urandom)};
            f = (ri && rd) ? (PRIO ? 1'b1 : ~last_d) : rd;
            round(ri, rd, it, dt, {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, {$urandom, $urandom},
                  $urandom_range(0, 2), ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1, f);
            last_d = (ri && rd) ? ~f : f;
        end

        // Data write whose owner pauses reqcyc mid-burst.
        tick;
        set_req(1'b1, 1'b1, 64'h3000, 13'h1fff);
        tick;
        bus_reqack = 1'b1;
        @(negedge clk);
        chk("pause_addr_ack", 64'(d_reqack), 64'd1);
        tick;
        for (int k = 0; k < NB; k++) begin
            if (k == 2) begin
                d_reqcyc = 1'b0;
                bus_reqack = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    chk("pause_cyc", 64'(bus_reqcyc), 64'd0);
                    chk("pause_owner", 64'(owner), 64'd2);
                    chk("pause_ack", 64'(d_reqack), 64'd0);
                    tick;
                end
            end
            set_req(1'b1, 1'b1, 64'h3100 + 64'(k), 13'h1fff);
            bus_reqack = 1'b1;
            @(negedge clk);
            chk("pause_data", bus_req, 64'h3100 + 64'(k));
            chk("pause_beat_ack", 64'(d_reqack), 64'd1);
            tick;
        end
        set_req(1'b1, 1'b0, '0, '0);
        bus_reqack = 1'b0;
        @(negedge clk);
        chk("pause_end_owner", 64'(owner), 64'd0);

        // Stray response beat while idle.
        tick;
        bus_respcyc = 1'b1;
        bus_resp = 64'hBAD;
        @(negedge clk);
        chk("stray_respack", 64'(bus_respack), 64'd1);
        chk("stray_routed", 64'(i_respcyc | d_respcyc), 64'd0);
        chk("stray_pre", 64'(stray_err), 64'd0);
        tick;
        bus_respcyc = 1'b0;
        @(negedge clk);
        chk("stray_set", 64'(stray_err), 64'd1);
        chk("stray_respack_off", 64'(bus_respack), 64'd0);
        repeat (3) tick;
        @(negedge clk);
        chk("stray_sticky", 64'(stray_err), 64'd1);

        // Reset arriving on beat 3 of a fetch read.
        tick;
        set_req(1'b0, 1'b1, 64'h4000, 13'h0009);
        tick;
        bus_reqack = 1'b1;
        @(negedge clk);
        tick;
        set_req(1'b0, 1'b0, '0, '0);
        bus_reqack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus_respcyc = 1'b1;
            bus_resp = 64'(k);
            @(negedge clk);
            chk("pre_rst_beat", 64'(i_respcyc), 64'd1);
            tick;
        end
        bus_resp = 64'd3;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_beat_noack", 64'(bus_respack), 64'd0);
        tick;
        reset = 1'b0;
        bus_respcyc = 1'b0;
        @(negedge clk);
        chk("midrst_owner", 64'(owner), 64'd0);
        chk("midrst_buscyc", 64'(bus_reqcyc), 64'd0);
        chk("midrst_respack", 64'(bus_respack), 64'd0);
        chk("midrst_reqack", 64'(i_reqack | d_reqack), 64'd0);
        chk("midrst_respcyc", 64'(i_respcyc | d_respcyc), 64'd0);
        chk("midrst_stray", 64'(stray_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
